// File: rtl/fp_norm_pkg.sv
// Shared types for the FP normalizer pipeline: stage-1 capture record and
// stage-2 result record, sized for the default datapath configuration.
package fp_norm_pkg;

  localparam int FP_WIDTH = 24;
  localparam int FP_EW    = 8;
  localparam int FP_CW    = $clog2(FP_WIDTH + 1);

  typedef struct packed {
    logic [FP_WIDTH-1:0] mant;
    logic [FP_EW-1:0]    exp;
    logic [FP_CW-1:0]    cnt;
  } fp_norm_s1_t;

  typedef struct packed {
    logic [FP_WIDTH-1:0] mant;
    logic [FP_EW-1:0]    exp;
    logic                zero;
    logic                subnorm;
  } fp_norm_res_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fp_norm_pipe_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module norm_lzc
  import fp_norm_pkg::*;
#(
  parameter  int WIDTH = FP_WIDTH,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] mant,
  output logic [CW-1:0]    cnt
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (mant[i]) cnt = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage mantissa normalizer with valid/ready handshakes on both sides;
// the shift is clamped so the exponent bottoms out at 1 (subnormal result).
module fp_norm_pipe
  import fp_norm_pkg::*;
#(
  parameter  int WIDTH = FP_WIDTH,
  parameter  int EW    = FP_EW,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [EW-1:0]    in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [EW-1:0]    out_exp,
  output logic             out_zero,
  output logic             out_subnorm
);

  // Wide enough that exp-1 and the zero count compare without wrapping.
  localparam int MW = max_int(EW, CW) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] mant;
    logic [EW-1:0]    exp;
    logic [CW-1:0]    cnt;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] mant;
    logic [EW-1:0]    exp;
    logic             zero;
    logic             subnorm;
  } res_t;

  s1_t           s1_q;
  res_t          s2_q;
  res_t          res_d;
  logic          s1_valid;
  logic          s2_valid;
  logic          s1_adv;
  logic          s2_adv;
  logic [CW-1:0] in_cnt;
  logic [MW-1:0] exp_ext;
  logic [MW-1:0] cnt_ext;
  logic [MW-1:0] lim;
  logic [MW-1:0] shift;

  norm_lzc #(.WIDTH(WIDTH)) u_lzc (
    .mant (in_mant),
    .cnt  (in_cnt)
  );

  assign s2_adv   = ~s2_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= '{mant: in_mant, exp: in_exp, cnt: in_cnt};
    end
  end

  always_comb begin
    exp_ext = MW'(s1_q.exp);
    cnt_ext = MW'(s1_q.cnt);
    lim     = exp_ext - MW'(1);
    shift   = '0;
    res_d   = '0;
    if (s1_q.mant == '0) begin
      res_d.zero = 1'b1;
    end else begin
      if (s1_q.exp != '0) shift = (cnt_ext < lim) ? cnt_ext : lim;
      res_d.mant    = s1_q.mant << shift;
      res_d.exp     = s1_q.exp - EW'(shift);
      res_d.subnorm = ~res_d.mant[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= res_d;
    end
  end

  assign out_valid   = s2_valid;
  assign out_mant    = s2_q.mant;
  assign out_exp     = s2_q.exp;
  assign out_zero    = s2_q.zero;
  assign out_subnorm = s2_q.subnorm;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Self-checking bench for fp_norm_pipe (WIDTH=8, EW=8): directed table,
// backpressure/reset sequences, and random streaming against a reference model.
module tb_fp_norm_pipe;

  localparam int WIDTH = 8;
  localparam int EW    = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_mant = '0;
  logic [7:0] in_exp = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_mant;
  logic [7:0] out_exp;
  logic       out_zero;
  logic       out_subnorm;

  typedef struct {
    logic [7:0] mant;
    logic [7:0] ex;
    logic       zero;
    logic       sub;
  } res_t;

  typedef struct {
    logic [7:0] in_mant;
    logic [7:0] in_exp;
    res_t       want;
  } vec_t;

  typedef struct {
    res_t res;
    int   acc;
    bit   lat;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[12];
  int   vecs = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   pops = 0;
  bit   lat_chk = 1'b1;

  fp_norm_pipe #(.WIDTH(WIDTH), .EW(EW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mant     (in_mant),
    .in_exp      (in_exp),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_mant    (out_mant),
    .out_exp     (out_exp),
    .out_zero    (out_zero),
    .out_subnorm (out_subnorm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: shift one bit at a time while the MSB is clear and exp stays above 1.
  function automatic res_t model(input logic [7:0] m, input logic [7:0] e);
    res_t r;
    int   mm;
    int   ee;
    mm = int'(m);
    ee = int'(e);
    if (mm == 0) begin
      r.mant = 8'h00; r.ex = 8'h00; r.zero = 1'b1; r.sub = 1'b0;
      return r;
    end
    if (ee != 0) begin
      while (mm < 128 && ee > 1) begin
        mm = mm * 2;
        ee = ee - 1;
      end
    end
    r.mant = 8'(mm);
    r.ex   = 8'(ee);
    r.zero = 1'b0;
    r.sub  = (mm < 128);
    return r;
  endfunction

  function automatic vec_t mk(input logic [7:0] m, input logic [7:0] e,
                              input logic [7:0] wm, input logic [7:0] we,
                              input logic wz, input logic ws);
    vec_t v;
    v.in_mant = m; v.in_exp = e;
    v.want.mant = wm; v.want.ex = we; v.want.zero = wz; v.want.sub = ws;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    vecs++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0h required %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Called at posedge+1; returns at accept edge+1 with in_valid dropped.
  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] e);
    int t;
    t = 0;
    in_mant  = m;
    in_exp   = e;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    checkOutput("accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Output monitor: every handshaken beat must match the oldest accepted input.
  always @(negedge clk) begin : mon
    sb_t e;
    if (reset_n) begin
      if (out_valid && out_ready) begin
        checkOutput("sb_underflow", 32'(sb.size() == 0), 32'd0);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("mon_mant", 32'(out_mant), 32'(e.res.mant));
          checkOutput("mon_exp", 32'(out_exp), 32'(e.res.ex));
          checkOutput("mon_zero", 32'(out_zero), 32'(e.res.zero));
          checkOutput("mon_subnorm", 32'(out_subnorm), 32'(e.res.sub));
          if (e.lat) checkOutput("mon_latency", 32'(cyc - e.acc), 32'd2);
        end
        pops++;
      end
      if (in_valid && in_ready) sb.push_back('{model(in_mant, in_exp), cyc, lat_chk});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] bp_m[4];
    logic [7:0] bp_e[4];
    res_t       r0;
    int         k;
    int         pops0;
    int         t;

    tbl[0]  = mk(8'h10, 8'd10,  8'h80, 8'd7,   1'b0, 1'b0);
    tbl[1]  = mk(8'h01, 8'd3,   8'h04, 8'd1,   1'b0, 1'b1);
    tbl[2]  = mk(8'h00, 8'd55,  8'h00, 8'd0,   1'b1, 1'b0);
    tbl[3]  = mk(8'h20, 8'd0,   8'h20, 8'd0,   1'b0, 1'b1);
    tbl[4]  = mk(8'h80, 8'd1,   8'h80, 8'd1,   1'b0, 1'b0);
    tbl[5]  = mk(8'h01, 8'd1,   8'h01, 8'd1,   1'b0, 1'b1);
    tbl[6]  = mk(8'h01, 8'd8,   8'h80, 8'd1,   1'b0, 1'b0);
    tbl[7]  = mk(8'h01, 8'd255, 8'h80, 8'd248, 1'b0, 1'b0);
    tbl[8]  = mk(8'hFF, 8'd0,   8'hFF, 8'd0,   1'b0, 1'b0);
    tbl[9]  = mk(8'h00, 8'd0,   8'h00, 8'd0,   1'b1, 1'b0);
    tbl[10] = mk(8'h03, 8'd4,   8'h18, 8'd1,   1'b0, 1'b1);
    tbl[11] = mk(8'h40, 8'd2,   8'h80, 8'd1,   1'b0, 1'b0);

    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_mant", 32'(out_mant), 32'd0);
    checkOutput("rst_out_exp", 32'(out_exp), 32'd0);
    checkOutput("rst_out_zero", 32'(out_zero), 32'd0);
    checkOutput("rst_out_subnorm", 32'(out_subnorm), 32'd0);
    #21 reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].in_mant, tbl[i].in_exp);
      checkOutput("tbl_early_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      checkOutput("tbl_out_valid", 32'(out_valid), 32'd1);
      checkOutput("tbl_mant", 32'(out_mant), 32'(tbl[i].want.mant));
      checkOutput("tbl_exp", 32'(out_exp), 32'(tbl[i].want.ex));
      checkOutput("tbl_zero", 32'(out_zero), 32'(tbl[i].want.zero));
      checkOutput("tbl_subnorm", 32'(out_subnorm), 32'(tbl[i].want.sub));
      @(posedge clk); #1;
    end

    // Backpressure: four beats offered while the consumer stalls, then released.
    bp_m[0] = 8'h05; bp_e[0] = 8'd9;
    bp_m[1] = 8'h30; bp_e[1] = 8'd2;
    bp_m[2] = 8'h81; bp_e[2] = 8'd4;
    bp_m[3] = 8'h00; bp_e[3] = 8'd7;
    r0 = model(bp_m[0], bp_e[0]);
    lat_chk = 1'b0;
    out_ready = 1'b0;
    k = 0;
    pops0 = 0;
    for (int c = 0; c < 11; c++) begin
      if (c == 6) begin
        out_ready = 1'b1;
        pops0 = pops;
      end
      if (c == 10) checkOutput("bp_rate", 32'(pops - pops0), 32'd4);
      in_valid = (k < 4);
      if (k < 4) begin
        in_mant = bp_m[k];
        in_exp  = bp_e[k];
      end
      @(negedge clk);
      if (c == 5) begin
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_accepted", 32'(k), 32'd2);
        checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_hold_mant", 32'(out_mant), 32'(r0.mant));
      end
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checkOutput("bp_all_accepted", 32'(k), 32'd4);
    checkOutput("bp_drained", 32'(sb.size()), 32'd0);
    lat_chk = 1'b1;

    // Reset with both stages holding data.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mant = 8'h11; in_exp = 8'd20;
    @(posedge clk); #1;
    in_mant = 8'h22;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("full_out_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_mant", 32'(out_mant), 32'd0);
    sb.delete();
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("postrst_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    applyStimulus(8'h40, 8'd5);
    @(posedge clk); #1;
    checkOutput("postrst_valid", 32'(out_valid), 32'd1);
    checkOutput("postrst_mant", 32'(out_mant), 32'h80);
    checkOutput("postrst_exp", 32'(out_exp), 32'd4);
    @(posedge clk); #1;

    // Random full-rate streaming, biased toward small exponents and mantissas.
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_mant  = 8'($urandom) >> $urandom_range(0, 8);
      in_exp   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      @(negedge clk);
      checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("stream_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_norm_pipe.md
Name: fp_norm_pipe

Overview:
- Two-stage pipelined normalizer directly downstream of the leading-zero counter in the FP datapath.
- Accepts an unnormalized mantissa and biased exponent, counts leading zeros, left-shifts the mantissa and decrements the exponent.
- Clamps the shift so the exponent never drops below 1, producing subnormals; flags zero results.
- Uses valid/ready handshakes on both sides with full-throughput backpressure.

Parameters:
- WIDTH, 24, mantissa width in bits (≥2).
- EW, 8, biased exponent width in bits.
- CW, $clog2(WIDTH+1), zero-count width; derived, not overridable.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_mant  in  WIDTH  unnormalized mantissa.
- in_exp  in  EW  biased exponent; 0 means already subnormal.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_mant  out  WIDTH  normalized mantissa.
- out_exp  out  EW  adjusted exponent.
- out_zero  out  1  mantissa was zero.
- out_subnorm  out  1  result nonzero and out_mant[WIDTH-1]==0.

Behaviour:
- Reset: all valid flags and all data registers clear to 0 asynchronously when reset_n is low.
  - out_valid=0, out_mant=0, out_exp=0, out_zero=0, out_subnorm=0.
  - in_ready=1 from the first clk edge after reset_n releases.
- Stage S1 register captures in_mant, in_exp and the zero count cnt on an in_valid && in_ready edge.
- Stage S2 register holds the final result.
- Outputs are driven straight from S2 registers. There is no combinational path from in_* to out_*.
- Handshake:
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv.
  - A stage's valid updates only when it advances. Data holds while stalled.
  - Latency is 2 cycles, accept edge to out_valid. Throughput is 1 beat/cycle when out_ready stays high.
- Shift computation, S1→S2:
  - exp==0 → shift=0, out_exp=0.
  - mant==0 → out_mant=0, out_exp=0, out_zero=1, out_subnorm=0, regardless of exp.
  - Otherwise shift = min(cnt, exp-1), out_exp = exp - shift, out_mant = mant << shift.
  - Compare in max(EW,CW)+1 bits with no wrap-around. exp-1 is never negative because the exp==0 case is handled first.
  - out_subnorm = ~out_zero & ~out_mant[WIDTH-1].
- Simultaneous events:
  - S2 drains and S1 refills in the same edge with no bubble.
  - A full pipe with out_ready=0 holds all data stable and drives in_ready=0.
- Reset mid-operation: in-flight beats are dropped. There is no partial output.
- out_valid must not depend combinationally on out_ready.

Decomposition:
- Package fp_norm_pkg holds the S1 typedef fp_norm_s1_t {mant, exp, cnt} and the S2 typedef fp_norm_res_t {mant, exp, zero, subnorm}. Both are parameterized via WIDTH/EW localparams.
- One sub-module: norm_lzc, the combinational leading-zero count. WIDTH in, CW out, count = WIDTH for all-zero input. It is instantiated in front of the S1 register.
- Shift/clamp logic stays inline.

Test Plan (WIDTH=8, EW=8):
- Basic normalize: mant=0x10, exp=10 → 2 cycles later out_mant=0x80, out_exp=7, zero=0, subnorm=0.
- Clamped subnormal: mant=0x01, exp=3 → out_mant=0x04, out_exp=1, subnorm=1.
- Zero mantissa and already-subnormal input:
  - mant=0x00, exp=55 → out_mant=0, out_exp=0, zero=1.
  - mant=0x20, exp=0 → out_mant=0x20, out_exp=0, subnorm=1.
- Backpressure: send 4 back-to-back beats with out_ready=0 for cycles 0-5.
  - in_ready drops after 2 beats are accepted.
  - Raising out_ready delivers all 4 in order with no loss or duplication, at 1 beat/cycle.
- Reset mid-flight: with S1 and S2 both valid, pulse reset_n low mid-cycle.
  - out_valid=0 immediately, without waiting for clk.
  - After release, a new beat with mant=0x40, exp=5 → out_mant=0x80, out_exp=4.
- Full-throughput streaming: 256 random beats with out_ready held high.
  - in_ready stays 1 throughout.
  - Every output matches the reference model at a fixed 2-cycle latency.
